// File: rtl/dec_seg7_2.sv
// Registered hex-to-7-segment decoder for a single display digit.
// Segment order is {a,b,c,d,e,f,g}: out[6] drives segment a, out[0] drives g.
// The nibble input is named "nibble" because "int" is a reserved word in
// SystemVerilog and cannot be used as a port name.
module dec_seg7_2 #(
  parameter bit ACTIVE_LOW = 1'b0  // 1: common-anode panel, every segment bit inverted
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nibble,
  output logic [6:0] out
);

  // All segments dark in the panel's own polarity.
  localparam logic [6:0] DARK = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] pattern;  // lit-high pattern for the current nibble
  logic [6:0] drive;    // pattern in panel polarity

  // Hex lookup, lit-high: a 1 means the segment is on.
  always_comb begin
    // NOTE: the default assignment ahead of the case keeps this block purely
    // combinational on every path, so no latch is inferred; it also makes an
    // unknown nibble fall through to a dark digit.
    pattern = 7'h00;
    unique case (nibble)
      4'h0: pattern = 7'h7E;
      4'h1: pattern = 7'h30;
      4'h2: pattern = 7'h6D;
      4'h3: pattern = 7'h79;
      4'h4: pattern = 7'h33;
      4'h5: pattern = 7'h5B;
      4'h6: pattern = 7'h5F;
      4'h7: pattern = 7'h70;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h7B;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h1F;
      4'hC: pattern = 7'h4E;
      4'hD: pattern = 7'h3D;
      4'hE: pattern = 7'h4F;
      4'hF: pattern = 7'h47;
      default: pattern = 7'h00;
    endcase
  end

  // Apply panel polarity before the output register.
  always_comb begin
    drive = ACTIVE_LOW ? ~pattern : pattern;
  end

  // Output register: one cycle of latency, blanked immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its inputs from before the edge; the async reset arm puts the
    // digit dark without waiting for a clock.
    if (!rst_n) begin
      out <= DARK;
    end else begin
      out <= drive;
    end
  end

endmodule

// File: tb/tb_dec_seg7_2.sv
// Self-checking bench for dec_seg7_2: drives a lit-high and an active-low
// instance with the same nibble stream; expected segment sets come from a
// letter-based reference table and are compared by an independent monitor.
module tb_dec_seg7_2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] nibble = 4'd8;
  logic [6:0] out_hi;
  logic [6:0] out_lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] exp_hi;
    logic [6:0] exp_lo;
  } exp_t;

  exp_t sb_q[$];

  dec_seg7_2 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .nibble(nibble), .out(out_hi)
  );

  dec_seg7_2 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .nibble(nibble), .out(out_lo)
  );

  always #5 clk = ~clk;

  // Reference: which segments light for each hex digit, by segment letter.
  function automatic logic [6:0] ref_seg(input int v);
    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    string s;
    logic [6:0] p;
    p = 7'h00;
    s = lit[v];
    for (int i = 0; i < s.len(); i++) begin
      p[6 - (int'(s[i]) - 97)] = 1'b1;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 7'h%02h, expected 7'h%02h", name, act, exp);
    end
  endtask

  // Present a nibble just after an edge; it is captured at the next edge.
  task automatic drive(input int v);
    exp_t e;
    @(posedge clk);
    #2;
    nibble = 4'(v);
    e.nib    = 4'(v);
    e.exp_hi = ref_seg(v);
    e.exp_lo = ~ref_seg(v);
    sb_q.push_back(e);
  endtask

  // Monitor: the output is valid every cycle; compare 1 ns after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("hi nib=%0h", e.nib), out_hi, e.exp_hi);
        check($sformatf("lo nib=%0h", e.nib), out_lo, e.exp_lo);
      end
    end
  end

  initial begin
    // Reset with nibble=8: dark immediately and across edges.
    #1 rst_n = 1'b0;
    #1;
    check("reset async hi", out_hi, 7'h00);
    check("reset async lo", out_lo, 7'h7F);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset held hi", out_hi, 7'h00);
      check("reset held lo", out_lo, 7'h7F);
    end
    #1 rst_n = 1'b1;
    drive(8);

    // Full sweep of all codes.
    for (int v = 0; v < 16; v++) drive(v);

    // Back-to-back changes, no drops.
    drive(3); drive(4); drive(5);

    // Boundary wrap 15 -> 0, then hold constant.
    drive(15); drive(0);
    repeat (4) drive(9);

    // Randomized stream.
    repeat (60) drive(int'($urandom_range(0, 15)));

    // Mid-sweep reset once nibble 6 has been captured.
    drive(5); drive(6);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid reset hi", out_hi, 7'h00);
    check("mid reset lo", out_lo, 7'h7F);
    @(posedge clk);
    #1;
    check("mid reset held hi", out_hi, 7'h00);
    check("mid reset held lo", out_lo, 7'h7F);
    #2 rst_n = 1'b1;
    drive(0); drive(1); drive(10);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
